sram_scan_unit: RTL and testbench
=================================

SRAM_SCAN_UNIT -- requirements
Module: sram_scan_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning SRAM address width (depth 2^ADDR_WIDTH).
REQ-003 SHALL have parameter NUM_WMASKS, default 4, meaning write-mask bits, one per DATA_WIDTH/NUM_WMASKS lane.
REQ-004 SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous reset, active-high.
- csb0, in, 1, active-low port-0 chip select; passed through to the macro.
- web0, in, 1, active-low port-0 write enable; passed through.
- wmask0, in, NUM_WMASKS, port-0 write mask; passed through.
- addr0, in, ADDR_WIDTH, port-0 address; passed through.
- din0, in, DATA_WIDTH, port-0 write data; passed through.
- dout0, out, DATA_WIDTH, port-0 read data from the macro.
- sram_csb1, out, 1, active-low macro port-1 select.
- sram_addr1, out, ADDR_WIDTH, macro port-1 address.
- sram_dout1, in, DATA_WIDTH, macro port-1 read data, valid 1 cycle after the select.
- start, in, 1, one-cycle pulse that begins a scan; sampled in IDLE only.
- mode, in, 1, 0 = single pass, 1 = continuous wrap; latched at start.
- base_addr, in, ADDR_WIDTH, first scan address; latched at start.
- end_addr, in, ADDR_WIDTH, last scan address, inclusive; latched at start.
- stride, in, ADDR_WIDTH, address increment; latched at start; 0 is treated as 1.
- abort, in, 1, stop issuing reads and drain.
- out_data, out, DATA_WIDTH, scanned word.
- out_addr, out, ADDR_WIDTH, address of out_data.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accept; a beat transfers when out_valid and out_ready are both high.
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle pulse at scan completion.

Function
REQ-005 SHALL implement states IDLE, SCAN and DRAIN.
REQ-006 IDLE->SCAN when start=1; the mode, base, end and stride values are latched and the read pointer is set to base_addr.
REQ-007 In SCAN, SHALL issue one read (sram_csb1=0, sram_addr1=pointer) per cycle when credit is available and no collision exists; otherwise sram_csb1=1.
REQ-008 Credit SHALL mean that output-FIFO occupancy plus the in-flight read count is less than 2. The output FIFO is 2 entries deep.
REQ-009 Read data SHALL be captured into the FIFO, together with its address, exactly 1 cycle after issue.
REQ-010 Collision SHALL mean csb0=0, web0=0 and addr0 equal to the pointer. On a collision the read is withheld that cycle and the pointer is held.
REQ-011 After each issue the pointer SHALL advance by stride, computed at ADDR_WIDTH+1 bits.
REQ-012 The issue SHALL be the last of the pass if the sum exceeds end_addr or exceeds 2^ADDR_WIDTH-1.
REQ-013 If base_addr > end_addr, exactly one read at base_addr SHALL be issued.
REQ-014 After the last issue in mode 0, the state SHALL go SCAN->DRAIN.
REQ-015 After the last issue in mode 1, the pointer SHALL reload base_addr and the state stays in SCAN.
REQ-016 abort=1 in SCAN SHALL cause SCAN->DRAIN with no further issues; abort is ignored in IDLE and DRAIN.
REQ-017 DRAIN->IDLE SHALL occur once there are no in-flight reads and the FIFO is empty; done=1 for that one cycle.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 out_valid SHALL equal FIFO non-empty; out_data and out_addr are the FIFO head and hold stable while out_valid=1 and out_ready=0.
REQ-020 Beats SHALL leave in issue order with no loss or duplication. Maximum throughput is 1 beat per cycle while out_ready=1.
REQ-021 Port-0 signals SHALL pass combinationally, unmodified.

Reset
REQ-022 When rst=1 at a clock edge, the next state SHALL be: IDLE; sram_csb1=1; sram_addr1=0; out_valid=0; out_data=0; out_addr=0; busy=0; done=0; FIFO empty; in-flight count 0.
REQ-023 Reset mid-scan SHALL discard in-flight and buffered data, and SHALL NOT pulse done.

Verification
REQ-024 SHALL cover: base=0, end=7, stride=1, mode 0, out_ready=1 -> addresses 0..7 on out_addr, one per cycle; done exactly once, 2 cycles after the last issue.
REQ-025 SHALL cover: base=250, end=255, stride=4, mode 0 -> reads at 250 and 254 only, then done; no wrap to low addresses.
REQ-026 SHALL cover: base=0, end=3, out_ready low for 10 cycles mid-scan -> at most 2 buffered beats, sram_csb1=1 while stalled, and all 4 beats in order after release.
REQ-027 SHALL cover: a port-0 write with addr0=5 while the pointer=5 -> no port-1 read that cycle, the read at 5 is issued next cycle, and it returns the newly written data.
REQ-028 SHALL cover: mode 1, base=2, end=4, abort after 7 issues -> out_addr sequence 2,3,4,2,3,4,2; then done; busy falls.
REQ-029 SHALL cover: rst pulse during SCAN with 2 beats buffered -> out_valid=0 next cycle, no done, and a new start operates normally.

Source files
------------

// File: rtl/sram_scan_unit.sv
// Scan engine for a dual-port SRAM macro: port 0 is a pass-through for the host,
// port 1 is driven by a credit-limited read pointer that streams words into a 2-entry FIFO.
module sram_scan_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                  state, state_d;
    logic                    mode_q;
    logic [ADDR_WIDTH-1:0]   base_q, end_q, stride_q, ptr;
    logic                    inflight;
    logic [ADDR_WIDTH-1:0]   inflight_addr;
    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic [ADDR_WIDTH-1:0]   fifo_addr [2];
    logic                    wr_idx, rd_idx;
    logic [1:0]              count;

    logic                    push, pop, collision, credit, issue, last, drain_ok;
    logic [ADDR_WIDTH:0]     ptr_sum;
    logic [2:0]              occupancy;

    assign dout0       = sram_dout0;
    assign sram_csb0   = csb0;
    assign sram_web0   = web0;
    assign sram_wmask0 = wmask0;
    assign sram_addr0  = addr0;
    assign sram_din0   = din0;

    // Output handshake: out_valid means the FIFO head is a real beat; the head stays
    // put until the cycle where out_valid and out_ready are both high, which retires it.
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_idx];
    assign out_addr  = fifo_addr[rd_idx];
    assign pop       = out_valid && out_ready;
    assign push      = inflight;

    // A beat leaving this cycle frees its slot in time for a read issued now.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign credit    = occupancy < (3'd2 + {2'b00, pop});
    assign collision = !csb0 && !web0 && (addr0 == ptr);
    assign issue     = (state == SCAN) && !abort && credit && !collision;

    assign ptr_sum   = {1'b0, ptr} + {1'b0, stride_q};
    assign last      = ptr_sum > {1'b0, end_q};
    assign drain_ok  = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

    assign sram_csb1  = !issue;
    assign sram_addr1 = ptr;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

    always_comb begin
        state_d = state;
        done    = 1'b0;
        case (state)
            IDLE:  if (start) state_d = SCAN;
            SCAN: begin
                if (abort) state_d = DRAIN;
                else if (issue && last && !mode_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_ok) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= 1'b0;
            base_q        <= '0;
            end_q         <= '0;
            stride_q      <= '0;
            ptr           <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_addr[0]  <= '0;
            fifo_addr[1]  <= '0;
            wr_idx        <= 1'b0;
            rd_idx        <= 1'b0;
            count         <= 2'd0;
        end else begin
            if (state == IDLE && start) begin
                mode_q   <= mode;
                base_q   <= base_addr;
                end_q    <= end_addr;
                stride_q <= (stride == '0) ? ADDR_WIDTH'(1) : stride;
                ptr      <= base_addr;
            end else if (issue) begin
                ptr <= last ? base_q : ptr_sum[ADDR_WIDTH-1:0];
            end
            inflight <= issue;
            if (issue) inflight_addr <= ptr;
            if (push) begin
                fifo_data[wr_idx] <= sram_dout1;
                fifo_addr[wr_idx] <= inflight_addr;
                wr_idx            <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sram_scan_unit.sv
// Directed bench for sram_scan_unit: behavioural dual-port macro, table of scan
// configurations with hand-derived address lists, and sequences for stall/collision/abort/reset.
module tb_sram_scan_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;
    logic        sram_csb1;
    logic [7:0]  sram_addr1;
    logic [31:0] sram_dout1;
    logic        start, mode, abort, out_ready;
    logic [7:0]  base_addr, end_addr, stride;
    logic [31:0] out_data;
    logic [7:0]  out_addr;
    logic        out_valid, busy, done;
    logic [1:0]  state_dbg;

    sram_scan_unit dut (
        .clk(clk), .rst(rst),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
        .start(start), .mode(mode), .base_addr(base_addr), .end_addr(end_addr),
        .stride(stride), .abort(abort),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- macro model ----------------
    function automatic logic [31:0] pattern(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {8'hA5, b, ~b, b ^ 8'h3C};
    endfunction

    logic [31:0] mem [256];
    logic [31:0] golden [256];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else begin
            if (!sram_csb0) begin
                if (!sram_web0) begin
                    for (int l = 0; l < 4; l++)
                        if (sram_wmask0[l]) mem[sram_addr0][8*l +: 8] <= sram_din0[8*l +: 8];
                end else begin
                    sram_dout0 <= mem[sram_addr0];
                end
            end
            if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [39:0] exp_q[$];
    int beat_cyc_q[$];
    int issue_cnt = 0, beat_cnt = 0, done_cnt = 0;
    int last_issue_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (!sram_csb1) begin
                issue_cnt++;
                last_issue_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                beat_cnt++;
                beat_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h/%0h required=none", out_addr, out_data);
                end else begin
                    chk("beat_addr_data", {24'h0, out_addr, out_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_scan(input logic [7:0] b, input logic [7:0] e, input logic [7:0] s,
                              input logic m);
        @(posedge clk); #1;
        base_addr = b; end_addr = e; stride = s; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic expect_addr(input logic [7:0] a);
        exp_q.push_back({a, golden[a]});
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_busy_low"}, {63'h0, busy}, 64'd0);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0]  base;
        logic [7:0]  end_a;
        logic [7:0]  stride;
        logic [3:0]  n;
        logic [63:0] addrs;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i0, b0, d0, n;
        logic [7:0] a;

        vecs[0] = '{base: 8'd0,   end_a: 8'd7,   stride: 8'd1,   n: 4'd8, addrs: 64'h0706_0504_0302_0100};
        vecs[1] = '{base: 8'd250, end_a: 8'd255, stride: 8'd4,   n: 4'd2, addrs: 64'h0000_0000_0000_FEFA};
        vecs[2] = '{base: 8'd10,  end_a: 8'd5,   stride: 8'd3,   n: 4'd1, addrs: 64'h0000_0000_0000_000A};
        vecs[3] = '{base: 8'd3,   end_a: 8'd9,   stride: 8'd0,   n: 4'd7, addrs: 64'h0009_0807_0605_0403};
        vecs[4] = '{base: 8'd0,   end_a: 8'd255, stride: 8'd100, n: 4'd3, addrs: 64'h0000_0000_00C8_6400};
        vecs[5] = '{base: 8'd255, end_a: 8'd255, stride: 8'd1,   n: 4'd1, addrs: 64'h0000_0000_0000_00FF};

        for (int i = 0; i < 256; i++) golden[i] = pattern(i);
        rst = 1'b1; mem_init = 1'b1;
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 8'h0; din0 = 32'h0;
        start = 1'b0; mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = 8'h0; end_addr = 8'h0; stride = 8'h0;
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;

        // reset state, sampled while rst is still asserted
        @(negedge clk);
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_sram_csb1", {63'h0, sram_csb1}, 64'd1);
        chk("rst_sram_addr1", {56'h0, sram_addr1}, 64'd0);
        chk("rst_out_data", {32'h0, out_data}, 64'd0);
        chk("rst_out_addr", {56'h0, out_addr}, 64'd0);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_state", {62'h0, state_dbg}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // port-0 pass-through: masked write then read back
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd9; din0 = 32'h1122_3344; wmask0 = 4'b0101;
        golden[9] = (golden[9] & 32'hFF00_FF00) | (32'h1122_3344 & 32'h00FF_00FF);
        @(negedge clk);
        chk("p0_csb", {63'h0, sram_csb0}, 64'd0);
        chk("p0_web", {63'h0, sram_web0}, 64'd0);
        chk("p0_wmask", {60'h0, sram_wmask0}, 64'h5);
        chk("p0_addr", {56'h0, sram_addr0}, 64'd9);
        chk("p0_din", {32'h0, sram_din0}, 64'h1122_3344);
        @(posedge clk); #1 web0 = 1'b1;
        @(posedge clk); #1 csb0 = 1'b1;
        @(negedge clk);
        chk("p0_dout", {32'h0, dout0}, {32'h0, golden[9]});

        // table of single-pass scans with out_ready held high
        for (int v = 0; v < 6; v++) begin
            n = int'(vecs[v].n);
            for (int k = 0; k < n; k++) begin
                a = vecs[v].addrs[8*k +: 8];
                expect_addr(a);
            end
            i0 = issue_cnt; b0 = beat_cnt;
            start_scan(vecs[v].base, vecs[v].end_a, vecs[v].stride, 1'b0);
            wait_done($sformatf("vec%0d", v), 100);
            chk($sformatf("vec%0d_issues", v), 64'(issue_cnt - i0), 64'(n));
            chk($sformatf("vec%0d_beats", v), 64'(beat_cnt - b0), 64'(n));
            if (beat_cnt - b0 == n)
                chk($sformatf("vec%0d_back_to_back", v),
                    64'(beat_cyc_q[b0 + n - 1] - beat_cyc_q[b0]), 64'(n - 1));
            chk($sformatf("vec%0d_done_latency", v), 64'(done_cyc - last_issue_cyc), 64'd2);
        end

        // downstream stall for 10 cycles after the first beat
        for (int k = 0; k < 4; k++) expect_addr(8'(k));
        i0 = issue_cnt; b0 = beat_cnt;
        start_scan(8'd0, 8'd3, 8'd1, 1'b0);
        for (int k = 0; k < 20 && beat_cnt == b0; k++) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_csb1_idle", {63'h0, sram_csb1}, 64'd1);
            chk("stall_valid", {63'h0, out_valid}, 64'd1);
            chk("stall_head_addr", {56'h0, out_addr}, 64'd1);
            chk("stall_head_data", {32'h0, out_data}, {32'h0, golden[1]});
        end
        chk("stall_buffered", 64'((issue_cnt - i0) - (beat_cnt - b0)), 64'd2);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("stall", 100);
        chk("stall_beats", 64'(beat_cnt - b0), 64'd4);

        // port-0 write collides with the read pointer at 5
        golden[5] = 32'hDEAD_BEEF;
        for (int k = 0; k < 8; k++) expect_addr(8'(k));
        start_scan(8'd0, 8'd7, 8'd1, 1'b0);
        repeat (5) @(posedge clk);
        #1 csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd5; din0 = 32'hDEAD_BEEF; wmask0 = 4'hF;
        @(negedge clk);
        chk("coll_read_withheld", {63'h0, sram_csb1}, 64'd1);
        chk("coll_ptr_held", {56'h0, sram_addr1}, 64'd5);
        @(posedge clk); #1 csb0 = 1'b1; web0 = 1'b1;
        @(negedge clk);
        chk("coll_read_next", {63'h0, sram_csb1}, 64'd0);
        chk("coll_read_addr", {56'h0, sram_addr1}, 64'd5);
        wait_done("coll", 100);

        // continuous mode, aborted after seven issues
        expect_addr(8'd2); expect_addr(8'd3); expect_addr(8'd4);
        expect_addr(8'd2); expect_addr(8'd3); expect_addr(8'd4); expect_addr(8'd2);
        i0 = issue_cnt;
        start_scan(8'd2, 8'd4, 8'd1, 1'b1);
        for (int k = 0; k < 50 && (issue_cnt - i0) < 7; k++) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done("wrap_abort", 100);
        chk("wrap_abort_issues", 64'(issue_cnt - i0), 64'd7);

        // reset in the middle of a scan with two beats buffered
        out_ready = 1'b0;
        start_scan(8'd0, 8'd7, 8'd1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midrst_buffered_valid", {63'h0, out_valid}, 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("midrst_busy", {63'h0, busy}, 64'd0);
        chk("midrst_csb1", {63'h0, sram_csb1}, 64'd1);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) expect_addr(8'(k));
        b0 = beat_cnt;
        start_scan(8'd0, 8'd3, 8'd1, 1'b0);
        wait_done("post_rst", 100);
        chk("post_rst_beats", 64'(beat_cnt - b0), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
